// File: rtl/arp_lookup_param_if.sv
// ---------------------------------------------------------------------------
// arp_lookup_param_if
//  Bundles the lookup handshake, the register read/write bus and the
//  hit/miss counters of arp_lookup_param.
//  master : requester side (drives lookup/register requests)
//  slave  : the ARP table itself
//  Signals:
//   lookup_req/search_ip            -> lookup request and key
//   lookup_done/hit/result_*        <- one-cycle result pulse plus held result
//   table_rd_req/addr               -> register read request
//   table_rd_ack/data               <- read response ({MAC,IP})
//   table_wr_req/addr/data          -> register write request
//   table_wr_ack                    <- write committed
//   hit_count/miss_count            <- saturating statistics
// ---------------------------------------------------------------------------
interface arp_lookup_param_if #(
    parameter int unsigned IP_W   = 32,
    parameter int unsigned MAC_W  = 48,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic                   lookup_req;
    logic [IP_W-1:0]        search_ip;
    logic                   lookup_done;
    logic                   lookup_hit;
    logic [MAC_W-1:0]       result_mac;
    logic [ADDR_W-1:0]      result_index;
    logic                   table_rd_req;
    logic [ADDR_W-1:0]      table_rd_addr;
    logic                   table_rd_ack;
    logic [MAC_W+IP_W-1:0]  table_rd_data;
    logic                   table_wr_req;
    logic [ADDR_W-1:0]      table_wr_addr;
    logic [MAC_W+IP_W-1:0]  table_wr_data;
    logic                   table_wr_ack;
    logic [CNT_W-1:0]       hit_count;
    logic [CNT_W-1:0]       miss_count;

    modport master (
        output lookup_req, search_ip,
        output table_rd_req, table_rd_addr,
        output table_wr_req, table_wr_addr, table_wr_data,
        input  lookup_done, lookup_hit, result_mac, result_index,
        input  table_rd_ack, table_rd_data, table_wr_ack,
        input  hit_count, miss_count
    );

    modport slave (
        input  lookup_req, search_ip,
        input  table_rd_req, table_rd_addr,
        input  table_wr_req, table_wr_addr, table_wr_data,
        output lookup_done, lookup_hit, result_mac, result_index,
        output table_rd_ack, table_rd_data, table_wr_ack,
        output hit_count, miss_count
    );
endinterface

// File: rtl/arp_lookup_param.sv
// ---------------------------------------------------------------------------
// arp_lookup_param
//  Parametrised ARP table (next-hop IP -> MAC) for the output-port lookup.
//  A lookup walks the table linearly through RAM port A, one entry per
//  cycle, and reports the lowest-index entry whose IP matches the key.
//  Entries with IP == 0 are empty and never match. Port B serves the
//  register read/write bus. Hit/miss counters saturate at all-ones.
//  Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts lookups and register accesses
//   bus   : arp_lookup_param_if slave (lookup, register bus, counters)
// ---------------------------------------------------------------------------
module arp_lookup_param #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned IP_W   = 32,
    parameter int unsigned MAC_W  = 48,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    arp_lookup_param_if.slave bus
);
    localparam int unsigned        ENT_W    = MAC_W + IP_W;
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic       {IDLE, SEARCH}        lk_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WR, R_RD}  reg_state_t;

    // Table storage, read-first on both ports
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  a_q;
    logic [ENT_W-1:0]  b_q;

    // Lookup path
    lk_state_t         lk_q, lk_d;
    logic              start, finish, match;
    logic [IP_W-1:0]   key;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] cmp_idx;
    logic              cmp_valid;
    logic              done_q, hit_q;
    logic [MAC_W-1:0]  mac_q;
    logic [ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    // Register path
    reg_state_t        r_q, r_d;
    logic [ADDR_W-1:0] b_addr_q;
    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic              rd_ack;

    // ---------------- RAM ----------------
    always_ff @(posedge clk) begin
        a_q <= mem[issue_addr];
    end

    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr_q] <= bus.table_wr_data;
        end
        b_q <= mem[b_addr];
    end

    // ---------------- Lookup FSM ----------------
    // The entry in a_q was addressed one cycle earlier; cmp_idx tracks it.
    assign match = cmp_valid && (key != '0) && (a_q[IP_W-1:0] == key);

    always_comb begin
        lk_d   = lk_q;
        start  = 1'b0;
        finish = 1'b0;
        case (lk_q)
            IDLE: begin
                if (bus.lookup_req) begin
                    start = 1'b1;
                    lk_d  = SEARCH;
                end
            end
            SEARCH: begin
                if (match || (cmp_valid && (cmp_idx == LAST_IDX))) begin
                    finish = 1'b1;
                    lk_d   = IDLE;
                end
            end
            default: lk_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_q <= IDLE;
        end else begin
            lk_q <= lk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key        <= '0;
            issue_addr <= '0;
            cmp_idx    <= '0;
            cmp_valid  <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            mac_q      <= '0;
            idx_q      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            done_q <= finish;
            if (start) begin
                key        <= bus.search_ip;
                issue_addr <= '0;
                cmp_valid  <= 1'b0;
            end else if ((lk_q == SEARCH) && !finish) begin
                // Issue the next entry; it is compared one cycle later.
                cmp_valid  <= 1'b1;
                cmp_idx    <= issue_addr;
                issue_addr <= issue_addr + ADDR_W'(1);
            end else if (finish) begin
                cmp_valid  <= 1'b0;
            end

            if (finish) begin
                hit_q <= match;
                mac_q <= match ? a_q[ENT_W-1:IP_W] : '0;
                idx_q <= match ? cmp_idx : '0;
                if (match) begin
                    if (hit_cnt != '1) begin
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end
                end else if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- Register FSM ----------------
    always_comb begin
        r_d = r_q;
        case (r_q)
            R_IDLE: begin
                if (bus.table_wr_req) begin
                    r_d = R_WR;
                end else if (bus.table_rd_req) begin
                    r_d = R_RD;
                end
            end
            R_WR:    r_d = R_IDLE;
            R_RD:    r_d = R_IDLE;
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= R_IDLE;
            b_addr_q <= '0;
        end else begin
            r_q <= r_d;
            if (r_q == R_IDLE) begin
                b_addr_q <= bus.table_wr_req ? bus.table_wr_addr : bus.table_rd_addr;
            end
        end
    end

    // In R_IDLE port B is addressed straight from the read request so the
    // data is already registered when R_RD is entered.
    assign b_addr = (r_q == R_IDLE) ? bus.table_rd_addr : b_addr_q;
    // Gating with reset keeps an aborted access from committing or acking.
    assign b_we   = (r_q == R_WR) && !reset;
    assign rd_ack = (r_q == R_RD) && !reset;

    // ---------------- Outputs ----------------
    assign bus.lookup_done   = done_q;
    assign bus.lookup_hit    = hit_q;
    assign bus.result_mac    = mac_q;
    assign bus.result_index  = idx_q;
    assign bus.hit_count     = hit_cnt;
    assign bus.miss_count    = miss_cnt;
    assign bus.table_wr_ack  = b_we;
    assign bus.table_rd_ack  = rd_ack;
    assign bus.table_rd_data = rd_ack ? b_q : '0;
endmodule

// File: tb/tb_arp_lookup_param.sv
// ---------------------------------------------------------------------------
// tb_arp_lookup_param
//  Self-checking bench for arp_lookup_param. A table-history model (log of
//  committed writes with their commit edges) predicts every output of the
//  default-size instance on every cycle; directed scenarios add literal
//  expectations. A second, tiny instance exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_arp_lookup_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arp_lookup_param_if #(.IP_W(32), .MAC_W(48), .ADDR_W(5), .CNT_W(32)) bus ();
    arp_lookup_param_if #(.IP_W(32), .MAC_W(48), .ADDR_W(2), .CNT_W(2))  bus2 ();

    arp_lookup_param #(.DEPTH(32), .ADDR_W(5), .IP_W(32), .MAC_W(48), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    arp_lookup_param #(.DEPTH(4), .ADDR_W(2), .IP_W(32), .MAC_W(48), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          e;
        int          a;
        logic [79:0] d;
    } wr_t;
    wr_t wlog[$];

    // Entry contents as seen by a read at edge e: last write committed strictly before e.
    function automatic logic [79:0] value_at(input int a, input int e);
        logic [79:0] v = '0;
        foreach (wlog[j]) begin
            if (wlog[j].a == a && wlog[j].e < e) v = wlog[j].d;
        end
        return v;
    endfunction

    bit          s_rst, s_req, s_wr, s_rd;
    logic [31:0] s_ip;
    int          s_waddr, s_raddr;
    logic [79:0] s_wdata;

    bit          lbusy = 0;
    int          n0 = 0;
    logic [31:0] mkey = '0;
    bit          e_done = 0, e_hit = 0;
    logic [47:0] e_mac = '0;
    int          e_idx = 0;
    logic [31:0] e_hc = '0, e_mc = '0;
    int          rstate = 0;
    logic [79:0] rexp = '0;

    always @(posedge clk) begin
        int k, found;
        logic [79:0] ent;
        cyc++;
        s_rst   = reset;
        s_req   = bus.lookup_req;
        s_ip    = bus.search_ip;
        s_wr    = bus.table_wr_req;
        s_rd    = bus.table_rd_req;
        s_waddr = int'(bus.table_wr_addr);
        s_raddr = int'(bus.table_rd_addr);
        s_wdata = bus.table_wr_data;
        #1;
        e_done = 0;
        if (s_rst) begin
            lbusy = 0; e_hit = 0; e_mac = '0; e_idx = 0; e_hc = '0; e_mc = '0; rstate = 0;
        end else begin
            if (!lbusy) begin
                if (s_req) begin
                    lbusy = 1; n0 = cyc; mkey = s_ip;
                end
            end else begin
                // Entry i is read at edge n0+i+1 and its result registered at n0+i+2.
                k = cyc - n0 - 2;
                found = -1;
                for (int i = 0; i <= k && i < 32 && found < 0; i++) begin
                    ent = value_at(i, n0 + i + 1);
                    if (mkey != 0 && ent[31:0] == mkey) found = i;
                end
                if ((found >= 0 && found == k) || (found < 0 && k == 31)) begin
                    e_done = 1;
                    e_hit  = (found >= 0);
                    if (e_hit) begin
                        ent   = value_at(found, n0 + found + 1);
                        e_mac = ent[79:32];
                        e_idx = found;
                        if (e_hc != 32'hFFFF_FFFF) e_hc++;
                    end else begin
                        e_mac = '0;
                        e_idx = 0;
                        if (e_mc != 32'hFFFF_FFFF) e_mc++;
                    end
                    lbusy = 0;
                end
            end
            case (rstate)
                0: begin
                    if (s_wr) begin
                        rstate = 1;
                        wlog.push_back('{e: cyc + 1, a: s_waddr, d: s_wdata});
                    end else if (s_rd) begin
                        rstate = 2;
                        rexp = value_at(s_raddr, cyc);
                    end
                end
                default: rstate = 0;
            endcase
        end
        chk("done",       80'(bus.lookup_done),  80'(e_done));
        chk("hit",        80'(bus.lookup_hit),   80'(e_hit));
        chk("mac",        80'(bus.result_mac),   80'(e_mac));
        chk("index",      80'(bus.result_index), 80'(e_idx));
        chk("hit_count",  80'(bus.hit_count),    80'(e_hc));
        chk("miss_count", 80'(bus.miss_count),   80'(e_mc));
        chk("wr_ack",     80'(bus.table_wr_ack), 80'(rstate == 1));
        chk("rd_ack",     80'(bus.table_rd_ack), 80'(rstate == 2));
        chk("rd_data",    bus.table_rd_data,     (rstate == 2) ? rexp : 80'h0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic reg_write(input int a, input logic [79:0] d);
        bit seen = 0;
        @(negedge clk);
        bus.table_wr_req  = 1'b1;
        bus.table_wr_addr = a[4:0];
        bus.table_wr_data = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.table_wr_ack) seen = 1;
        end
        bus.table_wr_req = 1'b0;
        if (!seen) chk("wr_ack_timeout", 80'(seen), 80'(1));
    endtask

    task automatic lookup_start(input logic [31:0] ip, output int acc);
        @(negedge clk);
        bus.lookup_req = 1'b1;
        bus.search_ip  = ip;
        acc = cyc + 1;
        @(negedge clk);
        bus.lookup_req = 1'b0;
    endtask

    task automatic lookup_wait(input int acc, output int lat);
        bit seen = 0;
        lat = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.lookup_done) begin
                seen = 1;
                lat  = cyc - acc;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("done_timeout", 80'(seen), 80'(1));
    endtask

    task automatic lookup(input logic [31:0] ip, output int lat);
        int acc;
        lookup_start(ip, acc);
        lookup_wait(acc, lat);
    endtask

    task automatic s_write(input int a, input logic [79:0] d);
        bit seen = 0;
        @(negedge clk);
        bus2.table_wr_req  = 1'b1;
        bus2.table_wr_addr = a[1:0];
        bus2.table_wr_data = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus2.table_wr_ack) seen = 1;
        end
        bus2.table_wr_req = 1'b0;
        if (!seen) chk("s_wr_ack_timeout", 80'(seen), 80'(1));
    endtask

    task automatic s_lookup(input logic [31:0] ip, output int lat);
        int acc;
        bit seen = 0;
        @(negedge clk);
        bus2.lookup_req = 1'b1;
        bus2.search_ip  = ip;
        acc = cyc + 1;
        @(negedge clk);
        bus2.lookup_req = 1'b0;
        lat = -1;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus2.lookup_done) begin
                seen = 1;
                lat  = cyc - acc;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("s_done_timeout", 80'(seen), 80'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int lat, acc;
        bit seen_wr, seen_rd, rd_first;
        logic [79:0] e7;
        bus.lookup_req = 0;  bus.search_ip = '0;
        bus.table_rd_req = 0; bus.table_rd_addr = '0;
        bus.table_wr_req = 0; bus.table_wr_addr = '0; bus.table_wr_data = '0;
        bus2.lookup_req = 0; bus2.search_ip = '0;
        bus2.table_rd_req = 0; bus2.table_rd_addr = '0;
        bus2.table_wr_req = 0; bus2.table_wr_addr = '0; bus2.table_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_done",  80'(bus.lookup_done), 80'(0));
        chk("reset_hitcnt", 80'(bus.hit_count),  80'(0));
        reset = 1'b0;

        for (int i = 0; i < 32; i++) reg_write(i, 80'h0);

        // 1: single entry hit at index 5
        reg_write(5, {48'h00AABBCCDDEE, 32'h0A000001});
        lookup(32'h0A000001, lat);
        chk("t1_latency", 80'(lat), 80'(7));
        chk("t1_hit",     80'(bus.lookup_hit), 80'(1));
        chk("t1_mac",     80'(bus.result_mac), 80'h00AABBCCDDEE);
        chk("t1_index",   80'(bus.result_index), 80'(5));
        chk("t1_hitcnt",  80'(bus.hit_count), 80'(1));

        // 2: absent key misses after the full walk
        lookup(32'hC0A80001, lat);
        chk("t2_latency", 80'(lat), 80'(33));
        chk("t2_hit",     80'(bus.lookup_hit), 80'(0));
        chk("t2_mac",     80'(bus.result_mac), 80'(0));
        chk("t2_misscnt", 80'(bus.miss_count), 80'(1));

        // 3: duplicate key, lowest index wins; zero key never matches
        reg_write(3, {48'h111111111111, 32'h0B000002});
        reg_write(9, {48'h999999999999, 32'h0B000002});
        lookup(32'h0B000002, lat);
        chk("t3_index", 80'(bus.result_index), 80'(3));
        chk("t3_mac",   80'(bus.result_mac), 80'h111111111111);
        lookup(32'h00000000, lat);
        chk("t3_zero_hit", 80'(bus.lookup_hit), 80'(0));
        chk("t3_zero_lat", 80'(lat), 80'(33));

        // 4: simultaneous write and read to the same index
        e7 = {48'h777777777777, 32'h0C000007};
        @(negedge clk);
        bus.table_wr_req = 1; bus.table_wr_addr = 5'd7; bus.table_wr_data = e7;
        bus.table_rd_req = 1; bus.table_rd_addr = 5'd7;
        seen_wr = 0; seen_rd = 0; rd_first = 0;
        for (int i = 0; i < 20 && !seen_rd; i++) begin
            @(negedge clk);
            if (bus.table_rd_ack) begin
                seen_rd = 1;
                if (!seen_wr) rd_first = 1;
                chk("t4_rd_data", bus.table_rd_data, e7);
                bus.table_rd_req = 0;
            end
            if (bus.table_wr_ack) begin
                seen_wr = 1;
                bus.table_wr_req = 0;
            end
        end
        bus.table_wr_req = 0; bus.table_rd_req = 0;
        chk("t4_rd_seen", 80'(seen_rd), 80'(1));
        chk("t4_wr_first", 80'(rd_first), 80'(0));

        // 5a: write ahead of the search pointer is seen
        lookup_start(32'h0A0000C8, acc);
        reg_write(20, {48'h202020202020, 32'h0A0000C8});
        lookup_wait(acc, lat);
        chk("t5a_hit",   80'(bus.lookup_hit), 80'(1));
        chk("t5a_index", 80'(bus.result_index), 80'(20));
        chk("t5a_lat",   80'(lat), 80'(22));
        // 5b: write behind the search pointer is not seen
        lookup_start(32'h0A0000C9, acc);
        for (int i = 0; i < 40 && cyc < acc + 10; i++) @(negedge clk);
        reg_write(0, {48'h000000000A0A, 32'h0A0000C9});
        lookup_wait(acc, lat);
        chk("t5b_hit", 80'(bus.lookup_hit), 80'(0));
        chk("t5b_lat", 80'(lat), 80'(33));
        lookup(32'h0A0000C9, lat);
        chk("t5c_index", 80'(bus.result_index), 80'(0));
        chk("t5c_lat",   80'(lat), 80'(2));

        // 6: reset mid-search aborts with no done pulse
        lookup_start(32'h0A000001, acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_no_done", 80'(bus.lookup_done), 80'(0));
        end
        chk("t6_hitcnt",  80'(bus.hit_count), 80'(0));
        chk("t6_misscnt", 80'(bus.miss_count), 80'(0));
        chk("t6_mac",     80'(bus.result_mac), 80'(0));

        // Saturation on a 2-bit-counter, 4-entry instance
        for (int i = 0; i < 4; i++) s_write(i, 80'h0);
        s_write(1, {48'h0000000000B1, 32'h00000007});
        for (int i = 0; i < 4; i++) s_lookup(32'h00000007, lat);
        chk("sat_hit_lat", 80'(lat), 80'(3));
        chk("sat_hitcnt",  80'(bus2.hit_count), 80'(3));
        for (int i = 0; i < 5; i++) s_lookup(32'h00000009, lat);
        chk("sat_miss_lat", 80'(lat), 80'(5));
        chk("sat_misscnt",  80'(bus2.miss_count), 80'(3));
        chk("sat_hitcnt_hold", 80'(bus2.hit_count), 80'(3));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
